// File: rtl/uart_sync_fifo.sv
// Parametrised single-clock FIFO sitting between the UART RX/TX engines and the
// core-side bus. Occupancy, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags, synchronous flush and optional first-word-fall-through.
// Count and all flags come from registered pointers, so wr_en/rd_en never reach
// a flag combinationally.
module uart_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_flush,
  input  logic              fifo_wr_en,
  input  logic [DATA_W-1:0] fifo_din,
  input  logic              fifo_rd_en,
  output logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              fifo_afull,
  output logic              fifo_aempty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_ovf,
  output logic              fifo_udf
);

  localparam logic [ADDR_W:0] FULL_V   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_V  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_V = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wrPtr_q, wrPtr_d;
  logic [ADDR_W:0]   rdPtr_q, rdPtr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              rdAcc;
  logic              wrAcc;
  logic [DATA_W-1:0] headData;

  // Occupancy falls out of the pointer difference; the extra MSB separates full from empty.
  assign count    = wrPtr_q - rdPtr_q;
  assign empty    = (count == '0);
  assign full     = (count == FULL_V);
  assign headData = mem[rdPtr_q[ADDR_W-1:0]];

  // A read frees a slot, so a write into a full FIFO still succeeds when paired with a read.
  assign rdAcc = fifo_rd_en && !empty && !fifo_flush;
  assign wrAcc = fifo_wr_en && (!full || rdAcc) && !fifo_flush;

  // Next-state: flush wins over everything, otherwise advance pointers and latch sticky errors.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (fifo_flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      if (FWFT != 0 && !empty) begin
        dout_d = headData;
      end
    end else begin
      if (wrAcc) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (rdAcc) begin
        rdPtr_d = rdPtr_q + 1'b1;
        dout_d  = headData;
        valid_d = 1'b1;
      end
      if (fifo_wr_en && !wrAcc) begin
        ovf_d = 1'b1;
      end
      if (fifo_rd_en && !rdAcc) begin
        udf_d = 1'b1;
      end
    end
  end

  // Control/state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wrAcc) begin
      mem[wrPtr_q[ADDR_W-1:0]] <= fifo_din;
    end
  end

  // In fall-through mode the head entry is shown directly; once empty the last shown byte holds.
  assign fifo_dout   = (FWFT != 0 && !empty) ? headData : dout_q;
  assign fifo_valid  = (FWFT != 0) ? !empty : valid_q;
  assign fifo_empty  = empty;
  assign fifo_full   = full;
  assign fifo_afull  = (count >= AFULL_V);
  assign fifo_aempty = (count <= AEMPTY_V);
  assign fifo_count  = count;
  assign fifo_ovf    = ovf_q;
  assign fifo_udf    = udf_q;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Self-checking bench for uart_sync_fifo: a registered-read instance and a
// fall-through instance share one stimulus stream and are compared against a
// queue-based reference model.
module tb_uart_sync_fifo;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 12;
  localparam int AEMPTY_TH = 2;
  localparam int ADDR_W    = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              wrEn;
  logic [DATA_W-1:0] din;
  logic              rdEn;

  logic [DATA_W-1:0] dout0, dout1;
  logic              valid0, valid1;
  logic              empty0, empty1, full0, full1, afull0, afull1, aempty0, aempty1;
  logic [ADDR_W:0]   count0, count1;
  logic              ovf0, ovf1, udf0, udf1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] modelQ[$];
  logic [DATA_W-1:0] modelDout;
  logic              modelValid;
  logic              modelOvf;
  logic              modelUdf;

  always #5 clk = ~clk;

  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH),
                   .AEMPTY_TH(AEMPTY_TH), .FWFT(0)) dutReg (
    .clk(clk), .rst(rst), .fifo_flush(flush), .fifo_wr_en(wrEn), .fifo_din(din),
    .fifo_rd_en(rdEn), .fifo_dout(dout0), .fifo_valid(valid0), .fifo_empty(empty0),
    .fifo_full(full0), .fifo_afull(afull0), .fifo_aempty(aempty0), .fifo_count(count0),
    .fifo_ovf(ovf0), .fifo_udf(udf0)
  );

  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH),
                   .AEMPTY_TH(AEMPTY_TH), .FWFT(1)) dutFwft (
    .clk(clk), .rst(rst), .fifo_flush(flush), .fifo_wr_en(wrEn), .fifo_din(din),
    .fifo_rd_en(rdEn), .fifo_dout(dout1), .fifo_valid(valid1), .fifo_empty(empty1),
    .fifo_full(full1), .fifo_afull(afull1), .fifo_aempty(aempty1), .fifo_count(count1),
    .fifo_ovf(ovf1), .fifo_udf(udf1)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model returns to its power-on picture.
  task automatic modelReset();
    modelQ.delete();
    modelDout  = '0;
    modelValid = 1'b0;
    modelOvf   = 1'b0;
    modelUdf   = 1'b0;
  endtask

  // Compare every observable output of both instances against the model.
  task automatic checkAll(input string tag);
    int sz;
    sz = modelQ.size();
    checkOutput({tag, ":count"},  32'(count0),  32'(sz));
    checkOutput({tag, ":empty"},  32'(empty0),  32'(sz == 0));
    checkOutput({tag, ":full"},   32'(full0),   32'(sz == DEPTH));
    checkOutput({tag, ":afull"},  32'(afull0),  32'(sz >= AFULL_TH));
    checkOutput({tag, ":aempty"}, 32'(aempty0), 32'(sz <= AEMPTY_TH));
    checkOutput({tag, ":ovf"},    32'(ovf0),    32'(modelOvf));
    checkOutput({tag, ":udf"},    32'(udf0),    32'(modelUdf));
    checkOutput({tag, ":valid"},  32'(valid0),  32'(modelValid));
    checkOutput({tag, ":dout"},   32'(dout0),   32'(modelDout));
    checkOutput({tag, ":fCount"}, 32'(count1),  32'(sz));
    checkOutput({tag, ":fValid"}, 32'(valid1),  32'(sz != 0));
    if (sz != 0) begin
      checkOutput({tag, ":fDout"}, 32'(dout1), 32'(modelQ[0]));
    end
  endtask

  // One clock of traffic: drive, clock, advance the model from the rules, compare.
  task automatic applyStimulus(input string tag, input logic w, input logic [DATA_W-1:0] d,
                               input logic r, input logic f);
    bit rdOk, wrOk;
    wrEn  = w;
    din   = d;
    rdEn  = r;
    flush = f;
    @(posedge clk);
    #1;
    if (f) begin
      modelQ.delete();
      modelOvf   = 1'b0;
      modelUdf   = 1'b0;
      modelValid = 1'b0;
    end else begin
      rdOk = r && (modelQ.size() > 0);
      wrOk = w && ((modelQ.size() < DEPTH) || rdOk);
      modelValid = rdOk;
      if (rdOk) modelDout = modelQ.pop_front();
      if (r && !rdOk) modelUdf = 1'b1;
      if (w && !wrOk) modelOvf = 1'b1;
      if (wrOk) modelQ.push_back(d);
    end
    wrEn  = 1'b0;
    rdEn  = 1'b0;
    flush = 1'b0;
    checkAll(tag);
  endtask

  // Reset asserted between clock edges; outputs must clear with no edge in between.
  task automatic asyncReset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll(tag);
    checkOutput({tag, ":fDout0"}, 32'(dout1), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkAll({tag, ":post"});
  endtask

  initial begin
    int nw;
    int guard;
    rst   = 1'b1;
    flush = 1'b0;
    wrEn  = 1'b0;
    rdEn  = 1'b0;
    din   = '0;
    modelReset();
    #12;
    checkAll("reset");
    checkOutput("reset:fDout", 32'(dout1), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, one rejected write, then drain in order
    for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    applyStimulus("overflow", 1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1'b0, '0, 1'b1, 1'b0);

    // Interleaved traffic with occupancy 0..5 so the pointers wrap
    nw = 0;
    guard = 0;
    while ((nw < 40 || modelQ.size() > 0) && guard < 400) begin
      bit w, r;
      w = (nw < 40) && (modelQ.size() < 5);
      r = (modelQ.size() > 0) && ($urandom_range(0, 1) == 1 || modelQ.size() == 5 || nw == 40);
      applyStimulus("wrap", w, 8'($urandom), r, 1'b0);
      if (w) nw++;
      guard++;
    end
    checkOutput("wrap:done", 32'(guard < 400), 32'd1);

    // Full with simultaneous write and read
    applyStimulus("clrFlags", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) applyStimulus("refill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    applyStimulus("fullWrRd", 1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain2", 1'b0, '0, 1'b1, 1'b0);

    // Empty with simultaneous write and read
    applyStimulus("emptyWrRd", 1'b1, 8'h3C, 1'b1, 1'b0);
    applyStimulus("readBack", 1'b0, '0, 1'b1, 1'b0);

    // Flush with a concurrent write
    for (int i = 0; i < 7; i++) applyStimulus("pre-flush", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, 8'hEE, 1'b0, 1'b1);

    // Fall-through visibility
    applyStimulus("fwftWr", 1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus("fwftIdle", 1'b0, '0, 1'b0, 1'b0);
    applyStimulus("fwftPop", 1'b0, '0, 1'b1, 1'b0);

    // Async reset in the middle of traffic
    for (int i = 0; i < 5; i++) applyStimulus("preRst", 1'b1, 8'($urandom), 1'b0, 1'b0);
    asyncReset("asyncRst");

    // Random mix biased so both ends of the occupancy range get exercised
    for (int i = 0; i < 600; i++) begin
      bit w, r, f;
      int bias;
      bias = (i / 100) % 2;
      w = ($urandom_range(0, 9) < (bias ? 7 : 4));
      r = ($urandom_range(0, 9) < (bias ? 3 : 6));
      f = ($urandom_range(0, 79) == 0);
      applyStimulus("random", w, 8'($urandom), r, f);
      if ($urandom_range(0, 199) == 0) asyncReset("randRst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
